// File: rtl/otter_io_pkg.sv
// Shared constants and types for the OTTER IOBUS responder: address map and segment encoding.
package otter_io_pkg;

  localparam logic [31:0] IO_SW_ADDR   = 32'h1100_0000;
  localparam logic [31:0] IO_LED_ADDR  = 32'h1100_0020;
  localparam logic [31:0] IO_SSEG_ADDR = 32'h1100_0040;

  typedef logic [7:0] seg_t;

  localparam seg_t SEG_BLANK = 8'hFF;

  // One-hot-low anode pattern for a digit index, [0] = rightmost.
  function automatic logic [3:0] digit_anode(logic [1:0] digit);
    return ~(4'b0001 << digit);
  endfunction

endpackage

// File: rtl/otter_io_responder_if.sv
// MCU IOBUS bundle: address, write data, write strobe and read data.
interface otter_io_responder_if;
  logic [31:0] IOBUS_ADDR;
  logic [31:0] IOBUS_OUT;
  logic        IOBUS_WR;
  logic [31:0] IOBUS_IN;

  modport master (
    output IOBUS_ADDR,
    output IOBUS_OUT,
    output IOBUS_WR,
    input  IOBUS_IN
  );

  modport slave (
    input  IOBUS_ADDR,
    input  IOBUS_OUT,
    input  IOBUS_WR,
    output IOBUS_IN
  );
endinterface

// File: rtl/sseg_hex_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern, dp always off.
module sseg_hex_decoder
  import otter_io_pkg::*;
(
  input  logic [3:0] nibble_i,
  output seg_t       seg_o
);

  // Bit order {dp, g, f, e, d, c, b, a}, all active-low.
  always_comb begin
    seg_o = SEG_BLANK;
    unique case (nibble_i)
      4'h0: seg_o = 8'hC0;
      4'h1: seg_o = 8'hF9;
      4'h2: seg_o = 8'hA4;
      4'h3: seg_o = 8'hB0;
      4'h4: seg_o = 8'h99;
      4'h5: seg_o = 8'h92;
      4'h6: seg_o = 8'h82;
      4'h7: seg_o = 8'hF8;
      4'h8: seg_o = 8'h80;
      4'h9: seg_o = 8'h90;
      4'hA: seg_o = 8'h88;
      4'hB: seg_o = 8'h83;
      4'hC: seg_o = 8'hC6;
      4'hD: seg_o = 8'hA1;
      4'hE: seg_o = 8'h86;
      4'hF: seg_o = 8'h8E;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/otter_io_responder.sv
// OTTER IOBUS responder: switches, LEDs and a scanned 4-digit hex display.
// Optional SSEG_BLANK_LEADING_EN blanks digits above the most-significant nonzero nibble.
module otter_io_responder
  import otter_io_pkg::*;
#(
  parameter int unsigned SCAN_W = 17,
  parameter int unsigned SW_W   = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  otter_io_responder_if.slave  iobus,
  input  logic [SW_W-1:0]      SWITCHES,
  output logic [SW_W-1:0]      LEDS,
  output logic [3:0]           ANODES,
  output seg_t                 CATHODES
);

  logic [SW_W-1:0]   sw_q;
  logic [SW_W-1:0]   led_q, led_d;
  logic [15:0]       sseg_q, sseg_d;
  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]        digit_q, digit_d;
  logic [3:0]        anodes_q, anodes_d;
  seg_t              cathodes_q, cathodes_d;

  logic       wr_led, wr_sseg;
  logic [3:0] nibble;
  seg_t       nibble_seg;
  logic       blank;

  logic unused_wdata;
  assign unused_wdata = ^iobus.IOBUS_OUT[31:16];

  assign wr_led  = iobus.IOBUS_WR && (iobus.IOBUS_ADDR == IO_LED_ADDR);
  assign wr_sseg = iobus.IOBUS_WR && (iobus.IOBUS_ADDR == IO_SSEG_ADDR);

  always_comb begin
    iobus.IOBUS_IN = 32'h0;
    case (iobus.IOBUS_ADDR)
      IO_SW_ADDR:   iobus.IOBUS_IN = 32'(sw_q);
      IO_LED_ADDR:  iobus.IOBUS_IN = 32'(led_q);
      IO_SSEG_ADDR: iobus.IOBUS_IN = 32'(sseg_q);
      default:      iobus.IOBUS_IN = 32'h0;
    endcase
  end

  always_comb begin
    led_d  = wr_led  ? iobus.IOBUS_OUT[SW_W-1:0] : led_q;
    sseg_d = wr_sseg ? iobus.IOBUS_OUT[15:0]     : sseg_q;
  end

  always_comb begin
    scan_cnt_d = scan_cnt_q + SCAN_W'(1);
    digit_d    = (&scan_cnt_q) ? digit_q + 2'd1 : digit_q;
  end

  // Output stage sees the incoming digit but the currently held value, so a write
  // landing on a digit-advance edge shows up one cycle later.
  assign nibble = sseg_q[{digit_d, 2'b00} +: 4];

  sseg_hex_decoder u_decoder (
    .nibble_i (nibble),
    .seg_o    (nibble_seg)
  );

`ifdef SSEG_BLANK_LEADING_EN
  logic [1:0] msd;

  always_comb begin
    msd = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if (sseg_q[4*i +: 4] != 4'h0) msd = 2'(i);
    end
  end

  assign blank = (digit_d > msd);
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    anodes_d   = blank ? 4'hF : digit_anode(digit_d);
    cathodes_d = blank ? SEG_BLANK : nibble_seg;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sw_q       <= '0;
      led_q      <= '0;
      sseg_q     <= '0;
      scan_cnt_q <= '0;
      digit_q    <= '0;
      anodes_q   <= 4'hF;
      cathodes_q <= SEG_BLANK;
    end else begin
      sw_q       <= SWITCHES;
      led_q      <= led_d;
      sseg_q     <= sseg_d;
      scan_cnt_q <= scan_cnt_d;
      digit_q    <= digit_d;
      anodes_q   <= anodes_d;
      cathodes_q <= cathodes_d;
    end
  end

  assign LEDS     = led_q;
  assign ANODES   = anodes_q;
  assign CATHODES = cathodes_q;

endmodule

// File: tb/tb_otter_io_responder.sv
// Directed bench for otter_io_responder with a 3-bit scan counter (8 cycles per digit).
module tb_otter_io_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] switches;
  logic [15:0] leds;
  logic [3:0]  anodes;
  logic [7:0]  cathodes;

  int n_tests = 0;
  int n_fail  = 0;
  int n       = 0;  // edges since the last reset edge

  otter_io_responder_if bus ();

  otter_io_responder #(
    .SCAN_W (3),
    .SW_W   (16)
  ) dut (
    .CLK      (clk),
    .RST      (rst),
    .iobus    (bus),
    .SWITCHES (switches),
    .LEDS     (leds),
    .ANODES   (anodes),
    .CATHODES (cathodes)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Display expectation {anodes, cathodes} for value 0x00C3.
  function automatic logic [11:0] exp_c3(input int d);
    case (d)
      0: return {4'b1110, 8'hB0};
      1: return {4'b1101, 8'hC6};
`ifdef SSEG_BLANK_LEADING_EN
      2: return {4'b1111, 8'hFF};
      default: return {4'b1111, 8'hFF};
`else
      2: return {4'b1011, 8'hC0};
      default: return {4'b0111, 8'hC0};
`endif
    endcase
  endfunction

  // Display expectation for value 0x4321.
  function automatic logic [11:0] exp_4321(input int d);
    case (d)
      0: return {4'b1110, 8'hF9};
      1: return {4'b1101, 8'hA4};
      2: return {4'b1011, 8'hB0};
      default: return {4'b0111, 8'h99};
    endcase
  endfunction

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    bus.IOBUS_ADDR = addr;
    bus.IOBUS_OUT  = data;
    bus.IOBUS_WR   = 1'b1;
    tick();
    bus.IOBUS_WR   = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    switches       = 16'h0;
    bus.IOBUS_ADDR = 32'h0;
    bus.IOBUS_OUT  = 32'h0;
    bus.IOBUS_WR   = 1'b0;

    tick();
    check("rst_leds", 32'(leds), 32'h0);
    check("rst_anodes", 32'(anodes), 32'hF);
    check("rst_cathodes", 32'(cathodes), 32'hFF);
    rst = 1'b0;
    n   = 0;

    tick();
    check("first_anodes", 32'(anodes), 32'hE);
    check("first_cathodes", 32'(cathodes), 32'hC0);

    // LED write: read before the edge still shows the old value
    bus.IOBUS_ADDR = 32'h1100_0020;
    bus.IOBUS_OUT  = 32'hDEAD_A5A5;
    bus.IOBUS_WR   = 1'b1;
    #1;
    check("led_read_pre", bus.IOBUS_IN, 32'h0);
    tick();
    bus.IOBUS_WR = 1'b0;
    #1;
    check("led_out", 32'(leds), 32'hA5A5);
    check("led_read", bus.IOBUS_IN, 32'h0000_A5A5);

    // Switch sampling latency and read-only behaviour
    switches       = 16'h1234;
    bus.IOBUS_ADDR = 32'h1100_0000;
    #1;
    check("sw_read_pre", bus.IOBUS_IN, 32'h0);
    tick();
    check("sw_read", bus.IOBUS_IN, 32'h0000_1234);
    bus_write(32'h1100_0000, 32'hFFFF_FFFF);
    check("sw_wr_ignored", bus.IOBUS_IN, 32'h0000_1234);
    check("sw_wr_leds", 32'(leds), 32'hA5A5);
    bus_write(32'h1100_0060, 32'h0000_FFFF);
    check("unmapped_wr_leds", 32'(leds), 32'hA5A5);
    check("unmapped_read", bus.IOBUS_IN, 32'h0);

    // Seven-segment write and one full scan
    bus_write(32'h1100_0040, 32'hFFFF_00C3);
    #1;
    check("sseg_read", bus.IOBUS_IN, 32'h0000_00C3);
    for (int i = 0; i < 32; i++) begin
      logic [11:0] e;
      tick();
      e = exp_c3((n / 8) % 4);
      check("scan_anodes", 32'(anodes), 32'(e[11:8]));
      check("scan_cathodes", 32'(cathodes), 32'(e[7:0]));
    end

    // Write landing on the digit-advance edge
    for (int g = 0; g < 8 && (n % 8) != 7; g++) tick();
    bus_write(32'h1100_0040, 32'h0000_4321);
    begin
      logic [11:0] e;
      e = exp_c3((n / 8) % 4);
      check("adv_old_anodes", 32'(anodes), 32'(e[11:8]));
      check("adv_old_cathodes", 32'(cathodes), 32'(e[7:0]));
      tick();
      e = exp_4321((n / 8) % 4);
      check("adv_new_anodes", 32'(anodes), 32'(e[11:8]));
      check("adv_new_cathodes", 32'(cathodes), 32'(e[7:0]));
    end

    // Reach digit 2 mid-slot, then reset with a concurrent LED write
    for (int g = 0; g < 40 && !(((n / 8) % 4) == 2 && (n % 8) == 3); g++) tick();
    check("mid_anodes", 32'(anodes), 32'hB);
    check("mid_cathodes", 32'(cathodes), 32'hB0);
    rst            = 1'b1;
    bus.IOBUS_ADDR = 32'h1100_0020;
    bus.IOBUS_OUT  = 32'h0000_1111;
    bus.IOBUS_WR   = 1'b1;
    tick();
    check("rst2_leds", 32'(leds), 32'h0);
    check("rst2_anodes", 32'(anodes), 32'hF);
    check("rst2_cathodes", 32'(cathodes), 32'hFF);
    check("rst2_led_read", bus.IOBUS_IN, 32'h0);
    rst          = 1'b0;
    bus.IOBUS_WR = 1'b0;
    n            = 0;

    tick();
    check("rst2_first_anodes", 32'(anodes), 32'hE);
    check("rst2_first_cathodes", 32'(cathodes), 32'hC0);
    bus.IOBUS_ADDR = 32'h1100_0060;
    #1;
    check("unmapped_read2", bus.IOBUS_IN, 32'h0);
    bus.IOBUS_ADDR = 32'h1100_0040;
    #1;
    check("sseg_rst_read", bus.IOBUS_IN, 32'h0);
    for (int g = 0; g < 7; g++) tick();
`ifdef SSEG_BLANK_LEADING_EN
    check("zero_d1_anodes", 32'(anodes), 32'hF);
    check("zero_d1_cathodes", 32'(cathodes), 32'hFF);
`else
    check("zero_d1_anodes", 32'(anodes), 32'hD);
    check("zero_d1_cathodes", 32'(cathodes), 32'hC0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
